dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's memory stage. It accepts the load/store request presented by the datapath in M (address, store data, funct3, write strobe) and completes it after a fixed, parameterised number of wait cycles. While the access is in flight it drives a stall request into the hazard unit. It also performs RV32I byte/halfword lane selection, sign/zero extension on loads, and misalignment detection.

---
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory for the M stage with stall, lane select and misalign detection
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     funct3_q;
    logic [31:0]    rdata_q;
    logic [31:0]    mem_q [DEPTH];

    logic           aligned;
    logic           accept;
    logic           access;
    logic [AW-1:0]  idx;
    logic [31:0]    word;
    logic [31:0]    shifted;
    logic [31:0]    rdata_d;
    logic [31:0]    lane_d;
    logic [3:0]     be_d;
    logic           unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    // funct3 011/110/111 match none of the size terms, so they count as misaligned
    assign aligned = (funct3[1:0] == 2'b00)
                   | (funct3[1:0] == 2'b01 & ~addr[0])
                   | (funct3 == 3'b010 & addr[1:0] == 2'b00);
    assign accept   = state_q == IDLE && req && aligned;
    assign stall    = accept || state_q == WAIT;
    assign misalign = state_q == IDLE && req && !aligned;
    assign done     = state_q == DONE;
    assign access   = state_q == WAIT && cnt_q == 4'd0;
    assign rdata    = rdata_q;

    assign idx     = addr_q[AW+1:2];
    assign word    = mem_q[idx];
    assign shifted = word >> {addr_q[1:0], 3'b000};

    // Load extension and store lane steering from the latched request
    always_comb begin
        rdata_d = funct3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                : funct3_q == 3'b100 ? {24'b0, shifted[7:0]}
                : funct3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                : funct3_q == 3'b101 ? {16'b0, shifted[15:0]}
                : word;
        be_d    = funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                : funct3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
        lane_d  = funct3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                : funct3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
                : wdata_q;
    end

    // Request FSM: latch on accept, count down wait cycles, register load data on the access edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rdata_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q  <= WAIT;
                    cnt_q    <= 4'(LATENCY - 1);
                    we_q     <= we;
                    addr_q   <= addr[AW+1:0];
                    wdata_q  <= wdata;
                    funct3_q <= funct3;
                end
                WAIT: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                    else begin
                        state_q <= DONE;
                        if (!we_q) rdata_q <= rdata_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-lane store; reset forces IDLE so a pending store never reaches this edge
    always_ff @(posedge clk) begin
        if (access && we_q)
            for (int i = 0; i < 4; i++)
                if (be_d[i]) mem_q[idx][8*i +: 8] <= lane_d[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven directed check of dmem_responder
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misalign;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rd = 32'd0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        mis;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[19];

    dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .stall(stall), .done(done), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic m, input logic [31:0] r);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.f3 = f; v.mis = m; v.rd = r;
        return v;
    endfunction

    // Entered in IDLE just after a rising edge; leaves just after the edge ending the DONE cycle
    task automatic run(input vec_t v, input int n);
        string nm;
        nm = $sformatf("v%0d", n);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; funct3 = v.f3;
        if (v.mis) begin
            @(negedge clk);
            chk({nm, " misalign"}, 32'(misalign), 32'd1);
            chk({nm, " stall"}, 32'(stall), 32'd0);
            chk({nm, " done"}, 32'(done), 32'd0);
            chk({nm, " rdata kept"}, rdata, exp_rd);
            @(posedge clk); #1;
            req = 1'b0;
            @(negedge clk);
            chk({nm, " stall after"}, 32'(stall), 32'd0);
            chk({nm, " done after"}, 32'(done), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k <= LAT; k++) begin
                @(negedge clk);
                chk($sformatf("%s stall c%0d", nm, k), 32'(stall), 32'd1);
                chk($sformatf("%s done c%0d", nm, k), 32'(done), 32'd0);
                chk($sformatf("%s misalign c%0d", nm, k), 32'(misalign), 32'd0);
                @(posedge clk); #1;
                if (k == 0) begin
                    addr = addr ^ 32'h104;
                    wdata = ~wdata;
                end
            end
            @(negedge clk);
            if (!v.we) exp_rd = v.rd;
            chk({nm, " done"}, 32'(done), 32'd1);
            chk({nm, " stall in done"}, 32'(stall), 32'd0);
            chk({nm, " rdata"}, rdata, exp_rd);
            @(posedge clk); #1;
            req = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h10,   32'hDEADBEEF, 3'b010, 0, 0);
        vecs[1]  = mk(0, 32'h10,   0,            3'b010, 0, 32'hDEADBEEF);
        vecs[2]  = mk(1, 32'h11,   32'h80,       3'b000, 0, 0);
        vecs[3]  = mk(0, 32'h11,   0,            3'b000, 0, 32'hFFFFFF80);
        vecs[4]  = mk(0, 32'h11,   0,            3'b100, 0, 32'h00000080);
        vecs[5]  = mk(0, 32'h10,   0,            3'b010, 0, 32'hDEAD80EF);
        vecs[6]  = mk(1, 32'h20,   32'h00005678, 3'b010, 0, 0);
        vecs[7]  = mk(1, 32'h22,   32'h1234ABCD, 3'b001, 0, 0);
        vecs[8]  = mk(0, 32'h22,   0,            3'b001, 0, 32'hFFFFABCD);
        vecs[9]  = mk(0, 32'h22,   0,            3'b101, 0, 32'h0000ABCD);
        vecs[10] = mk(0, 32'h20,   0,            3'b010, 0, 32'hABCD5678);
        vecs[11] = mk(0, 32'h13,   0,            3'b010, 1, 0);
        vecs[12] = mk(1, 32'h15,   32'hFFFF,     3'b001, 1, 0);
        vecs[13] = mk(0, 32'h00,   0,            3'b011, 1, 0);
        vecs[14] = mk(0, 32'h10,   0,            3'b010, 0, 32'hDEAD80EF);
        vecs[15] = mk(1, 32'h23,   32'hAA7F,     3'b000, 0, 0);
        vecs[16] = mk(0, 32'h23,   0,            3'b000, 0, 32'h0000007F);
        vecs[17] = mk(1, 32'h1000, 32'hCAFE0001, 3'b010, 0, 0);
        vecs[18] = mk(0, 32'h0,    0,            3'b010, 0, 32'hCAFE0001);

        #2;
        chk("reset rdata", rdata, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) run(vecs[i], i);
        run(mk(0, 32'h20, 0, 3'b010, 0, 32'h7FCD5678), 19);
        run(mk(0, 32'h20, 0, 3'b101, 0, 32'h00005678), 20);

        run(mk(1, 32'h40, 32'h11, 3'b010, 0, 0), 21);
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h55; funct3 = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0;
        #1;
        chk("midreset stall", 32'(stall), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset misalign", 32'(misalign), 32'd0);
        chk("midreset rdata", rdata, 32'd0);
        exp_rd = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post reset stall", 32'(stall), 32'd0);
        chk("post reset done", 32'(done), 32'd0);
        @(posedge clk); #1;
        run(mk(0, 32'h40, 0, 3'b010, 0, 32'h00000011), 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
